// File: rtl/fft_reorder_pkg.sv
// fft_reorder_pkg
//   Shared helpers for the radix-4 digit-reverse reorder buffer:
//     log4       - number of base-4 digits in a power-of-4 frame length
//     digitrev4  - D-digit base-4 reversal of an index
//     bank_of    - bank holding bin k (top digit + low digit, mod 4)
//     addr_of    - word address of bin k within its bank half
//     sample_t   - {real, imag} pair at the default sample width
package fft_reorder_pkg;

    localparam int unsigned SAMPLE_W = 32;

    typedef struct packed {
        logic [SAMPLE_W-1:0] re;
        logic [SAMPLE_W-1:0] im;
    } sample_t;

    function automatic int unsigned log4(input int unsigned n);
        int unsigned d;
        d = 0;
        for (int unsigned i = 0; i < 16; i++) begin
            if ((n >> (2 * i)) > 1) d = i + 1;
        end
        return d;
    endfunction

    // Low digit of j lands in the top digit of the result.
    function automatic int unsigned digitrev4(input int unsigned j, input int unsigned d);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 16; i++) begin
            if (i < d) r = (r << 2) | ((j >> (2 * i)) & 32'd3);
        end
        return r;
    endfunction

    function automatic int unsigned bank_of(input int unsigned k, input int unsigned d);
        return ((k >> (2 * d - 2)) + k) & 32'd3;
    endfunction

    function automatic int unsigned addr_of(input int unsigned k);
        return k >> 2;
    endfunction

endpackage

// File: rtl/fft_reorder_bank.sv
// fft_reorder_bank
//   Simple dual-port RAM, one write port and one registered read port.
//   Ports: clock; we/waddr/wdata write port; re/raddr read request;
//   rdata valid the cycle after re. A read of the word being written in
//   the same cycle returns the new data.
module fft_reorder_bank #(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned ADDR_W = 9
) (
    input  logic              clock,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [1 << ADDR_W];

    always_ff @(posedge clock) begin
        if (we) mem[waddr] <= wdata;
        // Bypass lets a drain start in the same cycle its frame completes.
        if (re) rdata <= (we && (waddr == raddr)) ? wdata : mem[raddr];
    end

endmodule

// File: rtl/fft_digit_reverse_reorder.sv
// fft_digit_reverse_reorder
//   Converts the four-lane digit-reversed radix-4 FFT output frame into
//   natural bin order using a ping-pong buffer of four banks.
//   Ports: clock, reset (sync, active-high); input_en + input_real/imag_0..3
//   (FFT lanes); output_en + output_real/imag_0..3 (natural-order bins,
//   4 per cycle). Optional macro FFT_REORDER_SOF_EN adds output_sof and
//   output_eof marking the first and last output beat of each frame.
module fft_digit_reverse_reorder
    import fft_reorder_pkg::*;
#(
    parameter int WIDTH          = 32,
    parameter int Num_of_samples = 1024
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             input_en,
    input  logic [WIDTH-1:0] input_real_0,
    input  logic [WIDTH-1:0] input_real_1,
    input  logic [WIDTH-1:0] input_real_2,
    input  logic [WIDTH-1:0] input_real_3,
    input  logic [WIDTH-1:0] input_imag_0,
    input  logic [WIDTH-1:0] input_imag_1,
    input  logic [WIDTH-1:0] input_imag_2,
    input  logic [WIDTH-1:0] input_imag_3,
`ifdef FFT_REORDER_SOF_EN
    output logic             output_sof,
    output logic             output_eof,
`endif
    output logic             output_en,
    output logic [WIDTH-1:0] output_real_0,
    output logic [WIDTH-1:0] output_real_1,
    output logic [WIDTH-1:0] output_real_2,
    output logic [WIDTH-1:0] output_real_3,
    output logic [WIDTH-1:0] output_imag_0,
    output logic [WIDTH-1:0] output_imag_1,
    output logic [WIDTH-1:0] output_imag_2,
    output logic [WIDTH-1:0] output_imag_3
);

    localparam int unsigned D  = log4(Num_of_samples);
    localparam int unsigned AW = 2 * D - 2;     // word address within a half

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] DRAIN = 1'b1;

    typedef struct packed {
        logic [WIDTH-1:0] re;
        logic [WIDTH-1:0] im;
    } pair_t;

    pair_t         in_pair    [4];
    logic [1:0]    lane_bank  [4];
    logic [AW-1:0] lane_addr  [4];
    pair_t         bank_wdata [4];
    logic [AW:0]   bank_waddr [4];
    pair_t         bank_q     [4];
    pair_t         out_pair   [4];

    logic [AW-1:0] wr_cnt, rd_cnt;
    logic          wr_ptr, rd_ptr;
    logic [1:0]    full, full_now, full_next;
    logic [0:0]    state;
    logic          wr_last, rd_issue, rd_last;
    logic          rd_v;
    logic [1:0]    rd_top;

    always_comb begin
        in_pair[0] = {input_real_0, input_imag_0};
        in_pair[1] = {input_real_1, input_imag_1};
        in_pair[2] = {input_real_2, input_imag_2};
        in_pair[3] = {input_real_3, input_imag_3};
    end

    // Per-lane destination of the current input beat.
    always_comb begin
        int unsigned k;
        k = 0;
        for (int unsigned l = 0; l < 4; l++) begin
            k            = digitrev4(32'({wr_cnt, l[1:0]}), D);
            lane_bank[l] = 2'(bank_of(k, D));
            lane_addr[l] = AW'(addr_of(k));
        end
    end

    // Lane-to-bank crossbar: each bank receives exactly one lane per beat.
    always_comb begin
        for (int unsigned b = 0; b < 4; b++) begin
            bank_wdata[b] = '0;
            bank_waddr[b] = '0;
            for (int unsigned l = 0; l < 4; l++) begin
                if (lane_bank[l] == 2'(b)) begin
                    bank_wdata[b] = in_pair[l];
                    bank_waddr[b] = {wr_ptr, lane_addr[l]};
                end
            end
        end
    end

    assign wr_last = input_en && (wr_cnt == '1);

    // A half completing this cycle counts as full so its drain can start at
    // once; the bank bypass covers the word still being written.
    always_comb begin
        full_now = full;
        if (wr_last) full_now[wr_ptr] = 1'b1;
    end

    assign rd_issue = (state == DRAIN) || full_now[rd_ptr];
    assign rd_last  = rd_issue && (rd_cnt == '1);

    always_comb begin
        full_next = full_now;
        if (rd_last) full_next[rd_ptr] = 1'b0;
    end

    for (genvar b = 0; b < 4; b++) begin : g_bank
        fft_reorder_bank #(
            .DATA_W(2 * WIDTH),
            .ADDR_W(AW + 1)
        ) u_bank (
            .clock(clock),
            .we   (input_en),
            .waddr(bank_waddr[b]),
            .wdata(bank_wdata[b]),
            .re   (rd_issue),
            .raddr({rd_ptr, rd_cnt}),
            .rdata(bank_q[b])
        );
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_cnt <= '0;
            wr_ptr <= 1'b0;
            rd_cnt <= '0;
            rd_ptr <= 1'b0;
            full   <= '0;
            state  <= IDLE;
            rd_v   <= 1'b0;
            rd_top <= '0;
        end else begin
            full   <= full_next;
            rd_v   <= rd_issue;
            rd_top <= rd_cnt[AW-1 -: 2];
            if (input_en) begin
                wr_cnt <= wr_cnt + 1'b1;
                if (wr_last) wr_ptr <= ~wr_ptr;
            end
            if (rd_issue) begin
                rd_cnt <= rd_cnt + 1'b1;
                if (rd_last) begin
                    rd_ptr <= ~rd_ptr;
                    state  <= full_now[~rd_ptr] ? DRAIN : IDLE;
                end else begin
                    state  <= DRAIN;
                end
            end
        end
    end

    // Bank-to-lane crossbar: output lane l reads bank (top digit + l) mod 4.
    always_ff @(posedge clock) begin
        if (reset) begin
            output_en <= 1'b0;
            for (int unsigned l = 0; l < 4; l++) out_pair[l] <= '0;
        end else begin
            output_en <= rd_v;
            if (rd_v) begin
                for (int unsigned l = 0; l < 4; l++) out_pair[l] <= bank_q[rd_top + 2'(l)];
            end
        end
    end

`ifdef FFT_REORDER_SOF_EN
    logic sof_q, eof_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            sof_q      <= 1'b0;
            eof_q      <= 1'b0;
            output_sof <= 1'b0;
            output_eof <= 1'b0;
        end else begin
            sof_q      <= rd_issue && (rd_cnt == '0);
            eof_q      <= rd_last;
            output_sof <= sof_q;
            output_eof <= eof_q;
        end
    end
`endif

    assign output_real_0 = out_pair[0].re;
    assign output_real_1 = out_pair[1].re;
    assign output_real_2 = out_pair[2].re;
    assign output_real_3 = out_pair[3].re;
    assign output_imag_0 = out_pair[0].im;
    assign output_imag_1 = out_pair[1].im;
    assign output_imag_2 = out_pair[2].im;
    assign output_imag_3 = out_pair[3].im;

endmodule

// File: tb/tb_fft_digit_reverse_reorder.sv
// tb_fft_digit_reverse_reorder
//   Scoreboard bench: three DUT instances (N = 16, 64, 1024). Drivers push
//   the natural-order bins plus the cycle they must appear in; a monitor per
//   instance pops and compares on every output_en cycle.
module tb_fft_digit_reverse_reorder;
    import fft_reorder_pkg::*;

    localparam int W = 32;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int errors   = 0;
    int checks   = 0;
    int done_cnt = 0;

    typedef struct packed {
        logic [31:0]    cycle;
        logic [4*W-1:0] re;
        logic [4*W-1:0] im;
        logic           sof;
        logic           eof;
    } exp_t;

    function automatic int rev4(int j, int d);
        int r = 0;
        int v = j;
        for (int i = 0; i < d; i++) begin
            r = r * 4 + v % 4;
            v = v / 4;
        end
        return r;
    endfunction

    // mode 0: real = bin + tag*4096, imag = -real; mode 1: max-value pattern
    function automatic logic [W-1:0] val_re(int mode, int tag, int bin);
        if (mode == 1) return 32'hFFFF_FFFF;
        return W'(bin + tag * 4096);
    endfunction

    function automatic logic [W-1:0] val_im(int mode, int tag, int bin);
        if (mode == 1) return 32'h8000_0000;
        return ~val_re(mode, tag, bin) + 1'b1;
    endfunction

    for (genvar g = 0; g < 3; g++) begin : g_n
        localparam int N     = (g == 0) ? 16 : (g == 1) ? 64 : 1024;
        localparam int D     = (g == 0) ? 2 : (g == 1) ? 3 : 5;
        localparam int BEATS = N / 4;

        logic         reset    = 1'b1;
        logic         input_en = 1'b0;
        logic [W-1:0] ir [4];
        logic [W-1:0] ii [4];
        logic         output_en;
        logic [W-1:0] o_re [4];
        logic [W-1:0] o_im [4];
        logic         o_sof, o_eof;
        exp_t         sb [$];

`ifndef FFT_REORDER_SOF_EN
        assign o_sof = 1'b0;
        assign o_eof = 1'b0;
`endif

        fft_digit_reverse_reorder #(
            .WIDTH(W),
            .Num_of_samples(N)
        ) u_dut (
            .clock        (clock),
            .reset        (reset),
            .input_en     (input_en),
            .input_real_0 (ir[0]),
            .input_real_1 (ir[1]),
            .input_real_2 (ir[2]),
            .input_real_3 (ir[3]),
            .input_imag_0 (ii[0]),
            .input_imag_1 (ii[1]),
            .input_imag_2 (ii[2]),
            .input_imag_3 (ii[3]),
`ifdef FFT_REORDER_SOF_EN
            .output_sof   (o_sof),
            .output_eof   (o_eof),
`endif
            .output_en    (output_en),
            .output_real_0(o_re[0]),
            .output_real_1(o_re[1]),
            .output_real_2(o_re[2]),
            .output_real_3(o_re[3]),
            .output_imag_0(o_im[0]),
            .output_imag_1(o_im[1]),
            .output_imag_2(o_im[2]),
            .output_imag_3(o_im[3])
        );

        task automatic beat(int mode, int tag, int c);
            sample_t s;
            for (int l = 0; l < 4; l++) begin
                s.re  = val_re(mode, tag, rev4(4 * c + l, D));
                s.im  = val_im(mode, tag, rev4(4 * c + l, D));
                ir[l] = s.re;
                ii[l] = s.im;
            end
            input_en = 1'b1;
        endtask

        task automatic push_frame(int mode, int tag);
            exp_t e;
            for (int oc = 0; oc < BEATS; oc++) begin
                e.cycle = 32'(cyc + 2 + oc);
                for (int l = 0; l < 4; l++) begin
                    e.re[l*W +: W] = val_re(mode, tag, 4 * oc + l);
                    e.im[l*W +: W] = val_im(mode, tag, 4 * oc + l);
                end
                e.sof = (oc == 0);
                e.eof = (oc == BEATS - 1);
                sb.push_back(e);
            end
        endtask

        task automatic frame(int mode, int tag, bit gapped);
            for (int c = 0; c < BEATS; c++) begin
                @(posedge clock); #1;
                beat(mode, tag, c);
                if (gapped && c != BEATS - 1) begin
                    @(posedge clock); #1;
                    input_en = 1'b0;
                end
            end
            push_frame(mode, tag);
        endtask

        task automatic idle(int n);
            @(posedge clock); #1;
            input_en = 1'b0;
            repeat (n - 1) @(posedge clock);
        endtask

        task automatic chk_reset();
            @(negedge clock);
            checks++;
            if (output_en !== 1'b0 || o_sof !== 1'b0 || o_eof !== 1'b0 ||
                {o_re[3], o_re[2], o_re[1], o_re[0]} !== '0 ||
                {o_im[3], o_im[2], o_im[1], o_im[0]} !== '0) begin
                errors++;
                $display("FAIL reset_state n=%0d cyc=%0d: en=%b sof=%b eof=%b re=%h im=%h, want all zero",
                         N, cyc, output_en, o_sof, o_eof,
                         {o_re[3], o_re[2], o_re[1], o_re[0]}, {o_im[3], o_im[2], o_im[1], o_im[0]});
            end
        endtask

        always @(negedge clock) begin
            exp_t e;
            if (output_en === 1'b1) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_output n=%0d cyc=%0d: output_en=1, want 0", N, cyc);
                end else begin
                    e = sb.pop_front();
                    if (32'(cyc) !== e.cycle) begin
                        errors++;
                        $display("FAIL timing n=%0d: beat seen at cycle %0d, want %0d", N, cyc, e.cycle);
                    end
                    checks++;
                    if ({o_re[3], o_re[2], o_re[1], o_re[0]} !== e.re ||
                        {o_im[3], o_im[2], o_im[1], o_im[0]} !== e.im) begin
                        errors++;
                        $display("FAIL data n=%0d cyc=%0d: re=%h im=%h, want re=%h im=%h", N, cyc,
                                 {o_re[3], o_re[2], o_re[1], o_re[0]}, {o_im[3], o_im[2], o_im[1], o_im[0]},
                                 e.re, e.im);
                    end
`ifdef FFT_REORDER_SOF_EN
                    checks++;
                    if (o_sof !== e.sof || o_eof !== e.eof) begin
                        errors++;
                        $display("FAIL sof_eof n=%0d cyc=%0d: sof=%b eof=%b, want sof=%b eof=%b",
                                 N, cyc, o_sof, o_eof, e.sof, e.eof);
                    end
`endif
                end
            end
        end

        initial begin
            for (int l = 0; l < 4; l++) begin
                ir[l] = '0;
                ii[l] = '0;
            end
            repeat (3) @(posedge clock);
            #1 reset = 1'b0;
            chk_reset();
            if (g == 0) begin
                frame(0, 0, 1'b0);              // basic reorder
                idle(8);
                frame(0, 0, 1'b1);              // gapped input
                idle(8);
                for (int c = 0; c < 2; c++) begin
                    @(posedge clock); #1;
                    beat(0, 9, c);              // partial frame, discarded
                end
                @(posedge clock); #1;
                input_en = 1'b0;
                reset    = 1'b1;
                @(posedge clock);
                chk_reset();
                @(posedge clock); #1;
                reset = 1'b0;
                chk_reset();
                frame(0, 5, 1'b0);
                idle(8);
                frame(0, 1, 1'b0);              // two back-to-back frames
                frame(0, 2, 1'b0);
            end else if (g == 1) begin
                frame(0, 1, 1'b0);              // three back-to-back frames
                frame(0, 2, 1'b0);
                frame(0, 3, 1'b0);
            end else begin
                frame(1, 0, 1'b0);              // max-value data
                frame(0, 7, 1'b0);
            end
            idle(4);
            for (int i = 0; i < 2000 && sb.size() != 0; i++) @(posedge clock);
            @(negedge clock);
            checks++;
            if (sb.size() != 0) begin
                errors++;
                $display("FAIL drain n=%0d: %0d expected beats never appeared, want 0", N, sb.size());
            end
            done_cnt++;
        end
    end

    initial begin
        for (int i = 0; i < 20000 && done_cnt < 3; i++) @(posedge clock);
        if (done_cnt < 3) begin
            errors++;
            $display("FAIL timeout: %0d of 3 instances finished, want 3", done_cnt);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
